seg_scan_display: RTL

SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

---
 rtl/seg_scan_display.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with frame-synchronous shadow load.
// Hex or octal digit slicing, leading-zero blanking, active-low drive.
module seg_scan_display #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 100000
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  octal_mode,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef struct packed {
    logic [4*DIGITS-1:0] val;
    logic [DIGITS-1:0]   dpm;
    logic                oct;
    logic                blk;
  } word_t;

  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  word_t             active;
  word_t             shadow;
  logic              pending;
  logic              tick;
  logic              wrap;
  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] upper_zero;
  logic [DIGITS-1:0] sel;
  logic [3:0]        cur;
  logic              cur_dp;
  logic              cur_blank;
  logic              z_acc;

  assign tick = (presc == PW'(PRESCALE - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      nib[i] = active.oct ? {1'b0, active.val[3*i +: 3]}
                          : active.val[4*i +: 4];
    end
  end

  // upper_zero[i]: digits i..top are all zero
  always_comb begin
    z_acc = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z_acc = z_acc & (nib[i] == 4'd0);
      upper_zero[i] = z_acc;
    end
  end

  always_comb begin
    sel = '0;
    cur = '0;
    cur_dp = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel[i] = 1'b1;
        cur = nib[i];
        cur_dp = active.dpm[i];
        cur_blank = active.blk && (i != 0) && upper_zero[i];
      end
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      presc       <= '0;
      idx         <= '0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      an          <= '1;
      seg         <= '1;
      dp          <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        idx <= wrap ? '0 : idx + 1'b1;
      frame_start <= wrap;
      // transfer sees the pre-load shadow when both coincide
      if (wrap && pending)
        active <= shadow;
      if (load) begin
        shadow <= '{val: value, dpm: dp_mask,
                    oct: octal_mode, blk: blank_lz};
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
      if (!enable) begin
        an  <= '1;
        seg <= '1;
        dp  <= 1'b1;
      end else begin
        an  <= ~sel;
        seg <= cur_blank ? 7'h7F : decode(cur);
        dp  <= ~cur_dp;
      end
    end
  end

endmodule
